// File: rtl/alu_dispatch.sv
// alu_dispatch: sequences register-file commands through the registered ALU and returns results.
// Optional ALU_DISPATCH_STATS_EN adds o_stat_done/o_stat_stall counters.
package pck_control;
    typedef enum logic [3:0] {
        alu_cpa  = 4'd0,
        alu_cpb  = 4'd1,
        alu_add  = 4'd2,
        alu_sub  = 4'd3,
        alu_and  = 4'd4,
        alu_or   = 4'd5,
        alu_xor  = 4'd6,
        alu_slt  = 4'd7,
        alu_sltu = 4'd8
    } sel_alu_op_e;
endpackage

module alu_dispatch
    import pck_control::*;
#(
    parameter int BITS = 8,
    parameter int NREGS = 8,
    localparam int RW = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_alu_rst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  sel_alu_op_e     i_cmd_op,
    input  logic [RW-1:0]   i_cmd_rd,
    input  logic [RW-1:0]   i_cmd_rs1,
    input  logic [RW-1:0]   i_cmd_rs2,
    input  logic [BITS-1:0] i_cmd_imm,
    input  logic            i_cmd_use_imm,
    output sel_alu_op_e     o_sel_op,
    output logic [BITS-1:0] o_op_a,
    output logic [BITS-1:0] o_op_b,
    input  logic [BITS-1:0] i_alu_res,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [BITS-1:0] o_res_data,
    output logic [RW-1:0]   o_res_rd
`ifdef ALU_DISPATCH_STATS_EN
    ,
    output logic [31:0]     o_stat_done,
    output logic [31:0]     o_stat_stall
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_e;

    state_e          r_state, w_next;
    logic [1:0]      r_alu_rst;
    sel_alu_op_e     r_sel_op;
    logic [BITS-1:0] r_op_a, r_op_b, r_res_data;
    logic [RW-1:0]   r_rd, r_res_rd;
    logic [BITS-1:0] r_regs [NREGS];
    logic            w_accept;

    assign o_alu_rst   = r_alu_rst[1];
    assign o_cmd_ready = (r_state == IDLE) && !o_alu_rst;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign o_res_valid = (r_state == RESP);
    assign o_sel_op    = r_sel_op;
    assign o_op_a      = r_op_a;
    assign o_op_b      = r_op_b;
    assign o_res_data  = r_res_data;
    assign o_res_rd    = r_res_rd;

    // ALU reset releases two edges after i_rst_n rises
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_alu_rst <= 2'b11;
        else          r_alu_rst <= {r_alu_rst[0], 1'b0};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? EXEC : IDLE;
            EXEC:    w_next = CAPT;
            CAPT:    w_next = RESP;
            default: w_next = i_res_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel_op   <= alu_cpa;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rd       <= '0;
            r_res_data <= '0;
            r_res_rd   <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_accept) begin
                r_sel_op <= i_cmd_op;
                r_op_a   <= r_regs[i_cmd_rs1];
                r_op_b   <= i_cmd_use_imm ? i_cmd_imm : r_regs[i_cmd_rs2];
                r_rd     <= i_cmd_rd;
            end
            // reg[0] is never written so it always reads as zero
            if (r_state == CAPT) begin
                r_res_data <= i_alu_res;
                r_res_rd   <= r_rd;
                if (r_rd != '0) r_regs[r_rd] <= i_alu_res;
            end
        end
    end

`ifdef ALU_DISPATCH_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stat_done  <= '0;
            o_stat_stall <= '0;
        end else if (r_state == RESP) begin
            if (i_res_ready) o_stat_done  <= o_stat_done + 32'd1;
            else             o_stat_stall <= o_stat_stall + 32'd1;
        end
    end
`endif
endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Command sequencer that sits in front of the registered `alu` datapath and also collects its result.
- Accepts ALU commands over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU's op-select and operand inputs, captures the ALU result one cycle later and writes it back to the register file.
- Presents each result downstream on a valid/ready handshake; one command is in flight at a time.

Parameters:
- BITS, 8, datapath width; equals the ALU BITS.
- NREGS, 8, register file depth; power of two, at least 2.
- RW, $clog2(NREGS), register index width; derived, not overridden.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- o_alu_rst  out  1  synchronous active-high reset for the ALU
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready
- i_cmd_op  in  sel_alu_op_e  operation (pck_control)
- i_cmd_rd  in  RW  destination register
- i_cmd_rs1  in  RW  source register for operand A
- i_cmd_rs2  in  RW  source register for operand B
- i_cmd_imm  in  BITS  immediate value
- i_cmd_use_imm  in  1  operand B = immediate instead of reg[rs2]
- o_sel_op  out  sel_alu_op_e  to ALU i_sel_op
- o_op_a  out  BITS  to ALU i_op_a
- o_op_b  out  BITS  to ALU i_op_b
- i_alu_res  in  BITS  from ALU o_res
- o_res_valid  out  1  result valid
- i_res_ready  in  1  result accepted
- o_res_data  out  BITS  result value
- o_res_rd  out  RW  destination index of the result

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - All registers are 0.
  - o_sel_op = alu_cpa; o_op_a, o_op_b, o_res_data and o_res_rd are 0.
  - o_res_valid = 0.
  - o_alu_rst = 1.
- o_alu_rst: two-flop chain, asynchronously set by i_rst_n low. Deasserts on the 2nd rising edge after i_rst_n rises.
- o_cmd_ready = (state == IDLE) && !o_alu_rst.
- State machine: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
  - IDLE:
    - On i_cmd_valid && o_cmd_ready, register o_sel_op = i_cmd_op.
    - Register o_op_a = reg[rs1].
    - Register o_op_b = i_cmd_use_imm ? i_cmd_imm : reg[rs2].
    - Latch rd; go to EXEC.
  - EXEC: operands are stable on the ALU inputs; the ALU registers its result at this edge. Go to CAPT.
  - CAPT:
    - o_res_data <= i_alu_res; o_res_rd <= latched rd.
    - reg[rd] <= i_alu_res, unless rd == 0.
    - Go to RESP.
  - RESP:
    - o_res_valid = 1; o_res_data and o_res_rd are held stable.
    - On i_res_ready, go to IDLE.
- Timing: command accepted at edge E0 gives o_res_valid high after E2. Minimum command period is 4 cycles.
- Operands stay stable from EXEC through RESP.
- reg[0] reads as 0 always; writes to it are dropped, but the result is still reported.
- rd == rs1 or rd == rs2: operands are read at accept time, before writeback, so the old value is used. The next command sees the new value, because writeback happens before IDLE.
- i_cmd_* is sampled only on the handshake. It may change freely otherwise.
- Unknown op encodings are passed through unchanged; whatever the ALU returns, 0 by default, is written back.
- Arithmetic is entirely in the ALU. This block does no width changes.
- Reset mid-operation (any state): state returns to IDLE, the in-flight command is discarded, and the register file clears to 0. No partial writeback occurs.

Optional Feature:
- ALU_DISPATCH_STATS_EN: adds two outputs, o_stat_done [31:0] and o_stat_stall [31:0].
  - o_stat_done counts results accepted (RESP && i_res_ready).
  - o_stat_stall counts cycles spent in RESP with i_res_ready low.
  - Both counters wrap at 2^32 and reset to 0.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then release: o_alu_rst stays high 2 edges after i_rst_n rises; o_cmd_ready rises the same cycle o_alu_rst falls; all outputs are 0.
- Load r1 = 0x05 and r2 = 0x03 (alu_cpb with imm), then alu_add rd=3 rs1=1 rs2=2 -> o_res_data=0x08, o_res_rd=3, o_res_valid after E2.
- alu_sub rd=4 rs1=2 rs2=1 (0x03 - 0x05) -> 0xFE; then alu_slt rd=5 rs1=4 rs2=1 -> 0x01; alu_sltu same operands -> 0x00.
- Write alu_cpb imm=0xAA to rd=0 -> result 0xAA reported; a following alu_cpa rs1=0 returns 0x00.
- Hold i_res_ready low for 5 cycles in RESP -> o_res_valid/data stable, o_cmd_ready low. With ALU_DISPATCH_STATS_EN, o_stat_stall=5 and o_stat_done increments by 1 on accept.
- Assert i_rst_n low during EXEC of alu_add into r3 -> r3 reads 0 after reset; o_res_valid never asserted for that command.
